spi_controller: RTL and testbench
=================================

// Module: spi_controller
// PURPOSE
// - SPI mode-0 initiator that drives the write-only register peripheral (addr0..addr4 bank).
// - Accepts one register write per valid/ready handshake; serialises a 16-bit frame on sclk/ncs/copi.
// - Frame, MSB first: R/W bit (1 = write), 7-bit address, 8-bit data.
// - Sits on the test/config side; all outputs are registered in the clk domain.
// PARAMETERS
// - CLK_DIV  4  clk cycles per SCLK half-period (H); legal 1..255
// - CS_GAP   2  min clk cycles ncs stays high between frames; legal 1..255
// PORTS
// - clk        in   1  system clock
// - rst_n      in   1  reset, synchronous, active-low
// - req_valid  in   1  write request present
// - req_ready  out  1  controller can accept; transfer when valid & ready
// - req_addr   in   7  register address (not range-checked; sent as given)
// - req_data   in   8  register data
// - busy       out  1  high from accept cycle until GAP ends
// - done       out  1  1-cycle pulse on the clk where ncs returns high
// - sclk       out  1  SPI clock, idles low
// - ncs        out  1  chip select, active-low, idles high
// - copi       out  1  controller-out data
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): ncs=1, sclk=0, copi=0, busy=0, done=0, req_ready=0; state=IDLE.
// - req_ready=1 only in IDLE and not during the reset cycle.
// - States: IDLE -> SHIFT -> HOLD -> GAP -> IDLE.
// - IDLE: on valid&ready, latch {1'b1,req_addr,req_data} into 16-bit shift reg; next cycle ncs=0,
//   copi=bit15, sclk=0, busy=1. Later changes on req_* have no effect.
// - SHIFT: 16 bits; per bit sclk low H cycles then high H cycles; copi changes only with sclk
//   falling (and at frame start), so it is stable >=H cycles around every rising edge.
// - After the 16th high phase: sclk falls, enter HOLD; copi=0; ncs held low H cycles.
// - HOLD end: ncs=1, done=1 for that cycle, enter GAP; ncs low time = 33*H clk cycles exactly.
// - GAP: ncs=1 for CS_GAP cycles (incl. the done cycle), then IDLE; req_ready rises next cycle.
// - Accept-to-done latency: 1 + 33*H cycles; back-to-back frame period: 1 + 33*H + CS_GAP.
// - Half-period counter: 8-bit, counts 0..CLK_DIV-1, tick at CLK_DIV-1; bit counter 5-bit.
// - req_valid while busy: ignored, not queued; requester must hold valid until ready.
// - Reset mid-frame: frame abandoned, outputs at reset values next edge, no done pulse.
// - ncs never glitches: sclk is low whenever ncs changes.
// CONFIGURATION
// - SPI_CTRL_READ_EN defined: adds ports req_write(in,1), cipo(in,1), rd_data(out,8),
//   rd_valid(out,1). R/W bit = req_write; when 0, cipo sampled on the clk where sclk rises for
//   the 8 data bits (MSB first), copi=0 during data phase; rd_data updated and rd_valid pulsed
//   together with done. rd_data resets to 0; write frames leave rd_data unchanged.
// - Undefined: no extra ports; R/W bit hard-wired 1; write-only.
// STRUCTURE
// - Package spi_pkg: state encoding (IDLE/SHIFT/HOLD/GAP), FRAME_W=16, ADDR_W=7, DATA_W=8,
//   RW_WRITE=1'b1, RW_READ=1'b0; shared with the peripheral and its bench.
// - Sub-module spi_clk_div: CLK_DIV half-period tick generator with sync clear; one instance.
// - Top holds FSM, shift reg, bit counter, output registers.
// TESTING
// - Bench pairs the DUT with the register peripheral (sclk/ncs/copi wired; peripheral rst_n shared).
// - Write addr=0 data=0xF0, CLK_DIV=4 -> addr0==0xF0 after ncs rises; done at accept+133 cycles.
// - Writes addr 1..4 with 0x01,0x02,0x04,0x80 back-to-back, valid held -> all four regs match;
//   ncs high >=CS_GAP between frames; req_ready low throughout each frame.
// - Write addr=5 data=0xAA -> frame on wire = 0x85AA bit-exact; addr0..addr4 unchanged.
// - rst_n low at bit 9 of a frame -> next edge ncs=1,sclk=0,copi=0; no done; target reg unchanged.
// - CLK_DIV=1, addr=3 data=0x5A -> sclk period 2 clk, addr3==0x5A; copi stable at every rising sclk.
// - SPI_CTRL_READ_EN: read addr=2 with cipo model returning 0xC3 -> rd_data=0xC3, rd_valid with done.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared definitions for the SPI register-write initiator and
//               its peripheral: FSM state encoding, frame field widths, R/W
//               bit values and a frame assembly helper.
// Ports       : none (package)
// Config      : SPI_CTRL_READ_EN (see spi_controller) uses RW_READ
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } spi_state_e;

    // Frame layout on the wire, MSB first: R/W, address, data.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic              rw,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        return {rw, addr, data};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_controller_if
// Description : Request/status bundle between a register-write requester and
//               the SPI initiator.
// Signals     : req_valid/req_ready handshake, req_addr (7), req_data (8),
//               busy, done; with SPI_CTRL_READ_EN also req_write, rd_data (8),
//               rd_valid.
// Modports    : master - requester side; slave - spi_controller side.
// Config      : SPI_CTRL_READ_EN adds the read-path signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_controller_if;
    import spi_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              busy;
    logic              done;
`ifdef SPI_CTRL_READ_EN
    logic              req_write;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output req_valid, req_addr, req_data, req_write,
        input  req_ready, busy, done, rd_data, rd_valid
    );
    modport slave (
        input  req_valid, req_addr, req_data, req_write,
        output req_ready, busy, done, rd_data, rd_valid
    );
`else
    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, busy, done
    );
    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, busy, done
    );
`endif

endinterface
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
// Module      : spi_clk_div
// Description : SCLK half-period tick generator. An 8-bit counter runs
//               0..CLK_DIV-1 while enabled; tick_o is high on the cycle the
//               counter sits at CLK_DIV-1. clr_i restarts the count at 0.
// Ports       : clk, rst_n (sync, active-low), clr_i, en_i -> tick_o
// Parameters  : CLK_DIV - clk cycles per half-period, 1..255
// Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clr_i,
    input  wire logic en_i,
    output logic      tick_o
);

    localparam logic [7:0] c_term = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            cnt_q <= 8'd0;
        end else if (en_i) begin
            cnt_q <= (cnt_q == c_term) ? 8'd0 : cnt_q + 8'd1;
        end
    end

    assign tick_o = en_i && (cnt_q == c_term);

endmodule
`default_nettype wire

// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
// Module      : spi_controller
// Description : SPI mode-0 initiator for a write-only register peripheral.
//               One register write is accepted per valid/ready handshake and
//               sent as a 16-bit MSB-first frame {R/W, addr[6:0], data[7:0]}.
//               ncs stays low for exactly 33 half-periods (32 for the bits
//               plus one hold), then stays high for at least CS_GAP cycles.
// Ports       : clk, rst_n (sync, active-low)
//               req_if (slave): req_valid/req_ready, req_addr, req_data,
//                               busy, done [, req_write, rd_data, rd_valid]
//               sclk, ncs, copi   - SPI pins, all registered
//               cipo              - only with SPI_CTRL_READ_EN
// Parameters  : CLK_DIV (1..255) clk cycles per SCLK half-period
//               CS_GAP  (1..255) min clk cycles ncs high between frames
// Config      : SPI_CTRL_READ_EN - R/W bit taken from req_write; read frames
//               drive copi=0 in the data phase, sample cipo on each rising
//               sclk of the data bits and report rd_data with rd_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_controller
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 2
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    spi_controller_if.slave req_if,
    output logic            sclk,
    output logic            ncs,
    output logic            copi
`ifdef SPI_CTRL_READ_EN
    ,
    input  wire logic       cipo
`endif
);

    localparam logic [7:0] c_gap_last = 8'(CS_GAP - 1);
    localparam logic [4:0] c_last_bit = 5'(FRAME_W - 1);

    spi_state_e         state_q;
    logic [FRAME_W-1:0] shreg_q;
    logic [4:0]         bit_q;
    logic [7:0]         gap_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic               sclk_q;
    logic               ncs_q;
    logic               copi_q;

    logic               tick;
    logic               div_clr;
    logic               div_en;
    logic [FRAME_W-1:0] frame_d;

`ifdef SPI_CTRL_READ_EN
    logic               rd_frame_q;
    logic [DATA_W-1:0]  rd_shift_q;
    logic [DATA_W-1:0]  rd_data_q;
    logic               rd_valid_q;

    // Read frames carry zeros in the data field so copi stays low while the
    // peripheral drives cipo.
    assign frame_d = build_frame(req_if.req_write, req_if.req_addr,
                                 req_if.req_write ? req_if.req_data : '0);
`else
    assign frame_d = build_frame(RW_WRITE, req_if.req_addr, req_if.req_data);
`endif

    // The divider only runs while ncs is low; holding it clear elsewhere
    // makes every frame start with a full low half-period.
    assign div_en  = (state_q == SHIFT) || (state_q == HOLD);
    assign div_clr = !div_en;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (div_clr),
        .en_i   (div_en),
        .tick_o (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_q      <= 5'd0;
            gap_q      <= 8'd0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sclk_q     <= 1'b0;
            ncs_q      <= 1'b1;
            copi_q     <= 1'b0;
`ifdef SPI_CTRL_READ_EN
            rd_frame_q <= 1'b0;
            rd_shift_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
`endif
        end else begin
            done_q     <= 1'b0;
`ifdef SPI_CTRL_READ_EN
            rd_valid_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (req_if.req_valid && ready_q) begin
                        shreg_q    <= frame_d;
                        copi_q     <= frame_d[FRAME_W-1];
                        ncs_q      <= 1'b0;
                        sclk_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        ready_q    <= 1'b0;
                        bit_q      <= 5'd0;
                        state_q    <= SHIFT;
`ifdef SPI_CTRL_READ_EN
                        rd_frame_q <= (req_if.req_write == RW_READ);
`endif
                    end else begin
                        // First cycle out of reset lands here with ready low.
                        ready_q <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (tick) begin
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
`ifdef SPI_CTRL_READ_EN
                            // bit_q 8..15 are the data bits.
                            if (rd_frame_q && bit_q[3]) begin
                                rd_shift_q <= {rd_shift_q[DATA_W-2:0], cipo};
                            end
`endif
                        end else begin
                            // copi only moves on the falling edge, so it is
                            // stable a full half-period around each rise.
                            sclk_q <= 1'b0;
                            if (bit_q == c_last_bit) begin
                                copi_q  <= 1'b0;
                                state_q <= HOLD;
                            end else begin
                                bit_q   <= bit_q + 5'd1;
                                shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
                                copi_q  <= shreg_q[FRAME_W-2];
                            end
                        end
                    end
                end

                HOLD: begin
                    if (tick) begin
                        ncs_q   <= 1'b1;
                        done_q  <= 1'b1;
                        gap_q   <= 8'd0;
                        state_q <= GAP;
`ifdef SPI_CTRL_READ_EN
                        if (rd_frame_q) begin
                            rd_data_q  <= rd_shift_q;
                            rd_valid_q <= 1'b1;
                        end
`endif
                    end
                end

                GAP: begin
                    // The done cycle counts as the first gap cycle.
                    if (gap_q == c_gap_last) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q + 8'd1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_if.req_ready = ready_q;
    assign req_if.busy      = busy_q;
    assign req_if.done      = done_q;
    assign sclk             = sclk_q;
    assign ncs              = ncs_q;
    assign copi             = copi_q;
`ifdef SPI_CTRL_READ_EN
    assign req_if.rd_data   = rd_data_q;
    assign req_if.rd_valid  = rd_valid_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_controller
// Description : Self-checking bench. Instance 0 uses CLK_DIV=4, instance 1
//               CLK_DIV=1; both have CS_GAP=2. A behavioural register
//               peripheral (addr0..addr4) decodes each SPI bus and watches
//               for timing violations on it.
// Config      : SPI_CTRL_READ_EN enables the read-path sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_controller;

    localparam int H0  = 4;
    localparam int H1  = 1;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_controller_if if0 ();
    spi_controller_if if1 ();

    logic [1:0] valid_s;
    logic [6:0] addr_s [2];
    logic [7:0] data_s [2];
    logic       sclk0, ncs0, copi0, sclk1, ncs1, copi1;
    logic [1:0] sclk_w, ncs_w, copi_w, ready_w, done_w, busy_w;

    assign if0.req_valid = valid_s[0];
    assign if0.req_addr  = addr_s[0];
    assign if0.req_data  = data_s[0];
    assign if1.req_valid = valid_s[1];
    assign if1.req_addr  = addr_s[1];
    assign if1.req_data  = data_s[1];
    assign sclk_w  = {sclk1, sclk0};
    assign ncs_w   = {ncs1, ncs0};
    assign copi_w  = {copi1, copi0};
    assign ready_w = {if1.req_ready, if0.req_ready};
    assign done_w  = {if1.done, if0.done};
    assign busy_w  = {if1.busy, if0.busy};

`ifdef SPI_CTRL_READ_EN
    logic [1:0] write_s;
    logic [1:0] cipo_s;
    logic [7:0] rd_byte;
    assign if0.req_write = write_s[0];
    assign if1.req_write = write_s[1];
`endif

    spi_controller #(.CLK_DIV(H0), .CS_GAP(GAP)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_if(if0.slave),
        .sclk(sclk0), .ncs(ncs0), .copi(copi0)
`ifdef SPI_CTRL_READ_EN
        , .cipo(cipo_s[0])
`endif
    );

    spi_controller #(.CLK_DIV(H1), .CS_GAP(GAP)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_if(if1.slave),
        .sclk(sclk1), .ncs(ncs1), .copi(copi1)
`ifdef SPI_CTRL_READ_EN
        , .cipo(cipo_s[1])
`endif
    );

    // ---------------- peripheral model + bus monitors ----------------
    int          cyc;
    int          bitn [2], last_bits [2], done_cnt [2], hi_len [2], last_rise [2];
    int          glitch_viol [2], copi_viol [2], per_viol [2], rdy_viol [2], gap_viol [2];
    logic [15:0] shf [2], last_frame [2];
    logic [7:0]  regs [2][5];
    logic [1:0]  ncs_p, sclk_p, copi_p;
    logic        rst_p;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                bitn[k]   = 0;
                hi_len[k] = 1000;
            end else begin
                if (!ncs_w[k] && ncs_p[k]) begin
                    bitn[k] = 0;
                    shf[k]  = 16'h0;
                    last_rise[k] = -1;
                    if (hi_len[k] < GAP) gap_viol[k]++;
                end
                if (!ncs_w[k] && sclk_w[k] && !sclk_p[k]) begin
                    shf[k] = {shf[k][14:0], copi_w[k]};
                    bitn[k]++;
                    if (last_rise[k] >= 0 && (cyc - last_rise[k]) != 2 * ((k == 0) ? H0 : H1))
                        per_viol[k]++;
                    last_rise[k] = cyc;
                end
                if (ncs_w[k] && !ncs_p[k]) begin
                    int ra;
                    last_frame[k] = shf[k];
                    last_bits[k]  = bitn[k];
                    ra = int'(shf[k][14:8]);
                    if (bitn[k] == 16 && shf[k][15] && ra < 5) regs[k][ra] = shf[k][7:0];
                end
                if (rst_p) begin
                    if (ncs_w[k] != ncs_p[k] && (sclk_w[k] || sclk_p[k])) glitch_viol[k]++;
                    if (!ncs_w[k] && !ncs_p[k] && copi_w[k] != copi_p[k] && !(sclk_p[k] && !sclk_w[k]))
                        copi_viol[k]++;
                    if (!ncs_w[k] && ready_w[k]) rdy_viol[k]++;
                    if (done_w[k]) done_cnt[k]++;
                end
                hi_len[k] = ncs_w[k] ? hi_len[k] + 1 : 0;
`ifdef SPI_CTRL_READ_EN
                cipo_s[k] = (bitn[k] >= 8 && bitn[k] < 16) ? rd_byte[15 - bitn[k]] : 1'b0;
`endif
            end
        end
        ncs_p  = ncs_w;
        sclk_p = sclk_w;
        copi_p = copi_w;
        rst_p  = rst_n;
    end

    // ---------------- checking helpers ----------------
    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: timed out", nm);
    endtask

    task automatic write_req(input int k, input logic [6:0] a, input logic [7:0] d, output int acc);
        int t = 0;
        acc = 0;
        @(negedge clk);
        valid_s[k] = 1'b1;
        addr_s[k]  = a;
        data_s[k]  = d;
        while (!ready_w[k] && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!ready_w[k]) begin
            timeout_fail("wait_ready");
            valid_s[k] = 1'b0;
            return;
        end
        @(negedge clk);
        acc = cyc;
        // Scramble the request bus to show it is not re-sampled.
        valid_s[k] = 1'b0;
        addr_s[k]  = ~a;
        data_s[k]  = ~d;
    endtask

    task automatic wait_done(input int k, output int dn);
        int t = 0;
        dn = -1;
        while (t < 2000) begin
            @(negedge clk);
            if (done_w[k]) begin
                dn = cyc;
                break;
            end
            t++;
        end
        if (dn < 0) timeout_fail("wait_done");
    endtask

    typedef struct {
        logic [6:0]  addr;
        logic [7:0]  data;
        logic [15:0] frame;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] exp_regs [5];
    logic [7:0] bb_data [4];
    int         acc, dn, d0, t;
    int         acc_b [4];

    initial begin
        vecs[0] = '{7'd0, 8'hF0, 16'h80F0};
        vecs[1] = '{7'd1, 8'h3C, 16'h813C};
        vecs[2] = '{7'd2, 8'hA5, 16'h82A5};
        vecs[3] = '{7'd3, 8'h0F, 16'h830F};
        vecs[4] = '{7'd4, 8'h7E, 16'h847E};
        vecs[5] = '{7'd5, 8'hAA, 16'h85AA};
        bb_data[0] = 8'h01; bb_data[1] = 8'h02; bb_data[2] = 8'h04; bb_data[3] = 8'h80;

        cyc = 0;
        ncs_p = 2'b11; sclk_p = 2'b00; copi_p = 2'b00; rst_p = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bitn[k] = 0; last_bits[k] = 0; done_cnt[k] = 0; hi_len[k] = 1000; last_rise[k] = -1;
            glitch_viol[k] = 0; copi_viol[k] = 0; per_viol[k] = 0; rdy_viol[k] = 0; gap_viol[k] = 0;
            shf[k] = 16'h0; last_frame[k] = 16'h0;
            for (int r = 0; r < 5; r++) regs[k][r] = 8'h00;
        end
        for (int r = 0; r < 5; r++) exp_regs[r] = 8'h00;
        valid_s = 2'b00;
        addr_s[0] = 7'd0; addr_s[1] = 7'd0; data_s[0] = 8'd0; data_s[1] = 8'd0;
`ifdef SPI_CTRL_READ_EN
        write_s = 2'b11;
        cipo_s  = 2'b00;
        rd_byte = 8'hC3;
`endif
        rst_n = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ncs",   {31'd0, ncs0},     32'd1);
        chk("rst_sclk",  {31'd0, sclk0},    32'd0);
        chk("rst_copi",  {31'd0, copi0},    32'd0);
        chk("rst_busy",  {31'd0, busy_w[0]}, 32'd0);
        chk("rst_done",  {31'd0, done_w[0]}, 32'd0);
        chk("rst_ready", {31'd0, ready_w[0]}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, ready_w[0]}, 32'd1);

        // Single writes from the vector table
        for (int i = 0; i < 6; i++) begin
            write_req(0, vecs[i].addr, vecs[i].data, acc);
            chk("busy_in_frame", {31'd0, busy_w[0]}, 32'd1);
            wait_done(0, dn);
            chk("done_latency", dn - acc + 1, 1 + 33 * H0);
            repeat (2) @(negedge clk);
            chk("frame_bits", last_bits[0], 16);
            chk("frame_wire", {16'd0, last_frame[0]}, {16'd0, vecs[i].frame});
            if (vecs[i].addr < 5) exp_regs[vecs[i].addr] = vecs[i].data;
            for (int r = 0; r < 5; r++) chk($sformatf("reg%0d", r), {24'd0, regs[0][r]}, {24'd0, exp_regs[r]});
        end

        // Back-to-back with valid held high
        @(negedge clk);
        valid_s[0] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            addr_s[0] = 7'(j + 1);
            data_s[0] = bb_data[j];
            t = 0;
            while (!ready_w[0] && t < 1000) begin
                @(negedge clk);
                t++;
            end
            if (!ready_w[0]) timeout_fail("b2b_ready");
            @(negedge clk);
            acc_b[j] = cyc;
            exp_regs[j + 1] = bb_data[j];
        end
        valid_s[0] = 1'b0;
        wait_done(0, dn);
        repeat (2) @(negedge clk);
        for (int j = 0; j < 3; j++) chk("b2b_period", acc_b[j + 1] - acc_b[j], 1 + 33 * H0 + GAP);
        for (int r = 0; r < 5; r++) chk($sformatf("b2b_reg%0d", r), {24'd0, regs[0][r]}, {24'd0, exp_regs[r]});
        chk("gap_viol",  gap_viol[0], 0);
        chk("ready_viol", rdy_viol[0], 0);

        // Reset in the middle of a frame
        write_req(0, 7'd4, 8'h11, acc);
        t = 0;
        while (bitn[0] < 9 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (bitn[0] < 9) timeout_fail("wait_bit9");
        d0 = done_cnt[0];
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ncs",  {31'd0, ncs0},  32'd1);
        chk("midrst_sclk", {31'd0, sclk0}, 32'd0);
        chk("midrst_copi", {31'd0, copi0}, 32'd0);
        chk("midrst_busy", {31'd0, busy_w[0]}, 32'd0);
        chk("midrst_done", {31'd0, done_w[0]}, 32'd0);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("midrst_no_done", done_cnt[0], d0);
        chk("midrst_reg4", {24'd0, regs[0][4]}, 32'h80);

        // CLK_DIV = 1 instance
        write_req(1, 7'd3, 8'h5A, acc);
        wait_done(1, dn);
        chk("div1_latency", dn - acc + 1, 1 + 33 * H1);
        repeat (2) @(negedge clk);
        chk("div1_frame", {16'd0, last_frame[1]}, 32'h835A);
        chk("div1_reg3",  {24'd0, regs[1][3]}, 32'h5A);
        chk("div1_period_viol", per_viol[1], 0);
        chk("div1_copi_viol",   copi_viol[1], 0);

`ifdef SPI_CTRL_READ_EN
        write_s[0] = 1'b0;
        write_req(0, 7'd2, 8'h00, acc);
        write_s[0] = 1'b1;
        wait_done(0, dn);
        chk("rd_valid", {31'd0, if0.rd_valid}, 32'd1);
        chk("rd_data",  {24'd0, if0.rd_data}, 32'hC3);
        repeat (2) @(negedge clk);
        chk("rd_frame", {16'd0, last_frame[0]}, 32'h0200);
        chk("rd_reg2",  {24'd0, regs[0][2]}, {24'd0, exp_regs[2]});
`endif

        // Whole-run bus hygiene on instance 0
        chk("copi_viol",   copi_viol[0], 0);
        chk("glitch_viol", glitch_viol[0] + glitch_viol[1], 0);
        chk("period_viol", per_viol[0], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
